// File: rtl/key_note_encoder_if.sv
// key_note_encoder_if: key inputs and selected-note outputs of the key encoder
interface key_note_encoder_if #(
  parameter int NUM_KEYS = 7
);
  localparam int IW = $clog2(NUM_KEYS + 1);
  logic [NUM_KEYS-1:0] key_raw;
  logic                enable;
  logic [NUM_KEYS-1:0] note_onehot;
  logic [IW-1:0]       note_idx;
  logic                note_valid;
  logic                note_change;
  modport master (output key_raw, enable, input note_onehot, note_idx, note_valid, note_change);
  modport slave (input key_raw, enable, output note_onehot, note_idx, note_valid, note_change);
endinterface

// File: rtl/key_note_encoder.sv
// key_note_encoder: synchronise, debounce and priority-encode keys into a registered note
module key_note_encoder #(
  parameter int NUM_KEYS        = 7,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int LATCH_MODE      = 0
) (
  input logic               clk,
  input logic               resetn,
  key_note_encoder_if.slave bus
);
  localparam int IW = $clog2(NUM_KEYS + 1);
  localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);
  logic [NUM_KEYS-1:0] sync1, sync2, deb, win_oh, onehot;
  logic [CW-1:0]       cnt [NUM_KEYS];
  logic [IW-1:0]       win, idx;
  logic                change, load;
  // two-flop synchroniser per key
  always_ff @(posedge clk) begin
    sync1 <= resetn ? bus.key_raw : '0;
    sync2 <= resetn ? sync1 : '0;
  end
  // per-key debounce: accept a new level only after it has held for the full count
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (!resetn) begin
        cnt[i] <= '0;
        deb[i] <= 1'b0;
      end else if (sync2[i] == deb[i]) begin
        cnt[i] <= '0;
      end else if (cnt[i] == TERM) begin
        deb[i] <= sync2[i];
        cnt[i] <= '0;
      end else begin
        cnt[i] <= cnt[i] + CW'(1);
      end
    end
  end
  // highest-numbered debounced key wins
  always_comb begin
    win = '0;
    win_oh = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (deb[i]) begin
        win = IW'(i + 1);
        win_oh = '0;
        win_oh[i] = 1'b1;
      end
    end
  end
  // latch mode only reloads while some key is held, so the last note survives release
  assign load = bus.enable && (LATCH_MODE == 0 || |deb);
  // output register; change pulses on the same edge that loads a different index
  always_ff @(posedge clk) begin
    if (!resetn) begin
      idx <= '0;
      onehot <= '0;
      change <= 1'b0;
    end else begin
      change <= load && (win != idx);
      if (load) begin
        idx <= win;
        onehot <= win_oh;
      end
    end
  end
  assign bus.note_idx = idx;
  assign bus.note_onehot = onehot;
  assign bus.note_valid = idx != '0;
  assign bus.note_change = change;
endmodule
